// File: rtl/png_pixel_packer_if.sv
// Pixel-in / word-out signal bundle for png_pixel_packer.
// master = upstream decoder and downstream sink side, slave = the packer.
interface png_pixel_packer_if #(
  parameter int WORD_BYTES = 69,
  parameter int CNT_W      = 7
);
  localparam int DATA_W = 8 * WORD_BYTES;

  logic              istart;
  logic [2:0]        icolortype;
  logic              ivalid;
  logic              iready;
  logic [7:0]        ipixelr;
  logic [7:0]        ipixelg;
  logic [7:0]        ipixelb;
  logic [7:0]        ipixela;
  logic              iflush;
  logic              owvalid;
  logic              oready;
  logic [DATA_W-1:0] oword;
  logic [CNT_W-1:0]  obytes;
  logic              olast;
  logic              odrop;
  logic [31:0]       opix_cnt;
  logic [31:0]       oword_cnt;

  modport master (
    output istart, icolortype, ivalid, ipixelr, ipixelg, ipixelb, ipixela, iflush, oready,
    input  iready, owvalid, oword, obytes, olast, odrop, opix_cnt, oword_cnt
  );

  modport slave (
    input  istart, icolortype, ivalid, ipixelr, ipixelg, ipixelb, ipixela, iflush, oready,
    output iready, owvalid, oword, obytes, olast, odrop, opix_cnt, oword_cnt
  );
endinterface

// File: rtl/png_pixel_packer.sv
// Packs decoded PNG pixel bytes LSB-first into WORD_BYTES-wide words with a last-tagged tail.
// Define PACKER_STATS_EN to build the per-frame pixel/word counters.
module png_pixel_packer #(
  parameter int WORD_BYTES = 69,
  parameter int CNT_W      = 7
) (
  input  logic              clk,
  input  logic              rstn,
  png_pixel_packer_if.slave bus
);
  localparam int               DATA_W = 8 * WORD_BYTES;
  localparam logic [CNT_W-1:0] LP_WB  = CNT_W'(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0]  r_fill, w_fill_nxt;
  logic [2:0]        r_bpp, w_bpp_nxt;
  logic              r_owvalid, w_owvalid_nxt;
  logic [DATA_W-1:0] r_oword, w_oword_nxt;
  logic [CNT_W-1:0]  r_obytes, w_obytes_nxt;
  logic              r_olast, w_olast_nxt;
  logic              r_odrop, w_odrop_nxt;

  logic                w_iready;
  logic                w_accept;
  logic                w_full;
  logic                w_out_free;
  logic [CNT_W-1:0]    w_sum;
  logic [CNT_W-1:0]    w_rem;
  logic [31:0]         w_pix;
  logic [DATA_W+31:0]  w_merged;

  function automatic logic [2:0] bpp_of(input logic [2:0] ct);
    case (ct)
      3'd0:       bpp_of = 3'd1;
      3'd1:       bpp_of = 3'd2;
      3'd2, 3'd4: bpp_of = 3'd3;
      default:    bpp_of = 3'd4;
    endcase
  endfunction

  assign w_sum      = r_fill + CNT_W'(r_bpp);
  assign w_rem      = w_sum - LP_WB;
  // Only registered terms: a stalled full word blocks any pixel that would complete the next one.
  assign w_iready   = (r_state == ST_RUN) && !(r_owvalid && (w_sum >= LP_WB));
  assign w_accept   = bus.ivalid && w_iready && !bus.istart;
  assign w_full     = w_accept && (w_sum >= LP_WB);
  assign w_out_free = !r_owvalid || bus.oready;
  assign w_merged   = {32'd0, r_acc} | ({{DATA_W{1'b0}}, w_pix} << {r_fill, 3'b000});

  // Select the significant pixel bytes for the latched colour type, R in the lowest byte.
  always_comb begin
    w_pix = 32'd0;
    case (r_bpp)
      3'd1:    w_pix = {24'd0, bus.ipixelr};
      3'd2:    w_pix = {16'd0, bus.ipixela, bus.ipixelr};
      3'd3:    w_pix = {8'd0, bus.ipixelb, bus.ipixelg, bus.ipixelr};
      default: w_pix = {bus.ipixela, bus.ipixelb, bus.ipixelg, bus.ipixelr};
    endcase
  end

  // Next-state, accumulator and output-register update.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_fill_nxt    = r_fill;
    w_bpp_nxt     = r_bpp;
    w_owvalid_nxt = r_owvalid && !bus.oready;
    w_oword_nxt   = r_oword;
    w_obytes_nxt  = r_obytes;
    w_olast_nxt   = r_olast;
    w_odrop_nxt   = 1'b0;
    if (bus.istart) begin
      w_state_nxt = ST_RUN;
      w_acc_nxt   = {DATA_W{1'b0}};
      w_fill_nxt  = {CNT_W{1'b0}};
      w_bpp_nxt   = bpp_of(bus.icolortype);
      w_odrop_nxt = (r_state != ST_IDLE) && (r_fill != {CNT_W{1'b0}});
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_full) begin
            // Full word leaves; the straddling tail restarts the accumulator at lane 0.
            w_owvalid_nxt = 1'b1;
            w_oword_nxt   = w_merged[DATA_W-1:0];
            w_obytes_nxt  = LP_WB;
            w_olast_nxt   = bus.iflush && (w_rem == {CNT_W{1'b0}});
            w_acc_nxt     = {{(DATA_W-32){1'b0}}, w_merged[DATA_W+31:DATA_W]};
            w_fill_nxt    = w_rem;
          end else if (w_accept) begin
            w_acc_nxt  = w_merged[DATA_W-1:0];
            w_fill_nxt = w_sum;
          end else begin
            w_acc_nxt  = r_acc;
            w_fill_nxt = r_fill;
          end
          if (bus.iflush) begin
            if (w_fill_nxt != {CNT_W{1'b0}}) begin
              w_state_nxt = ST_FLUSH;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (w_out_free) begin
            w_owvalid_nxt = 1'b1;
            w_oword_nxt   = r_acc;
            w_obytes_nxt  = r_fill;
            w_olast_nxt   = 1'b1;
            w_acc_nxt     = {DATA_W{1'b0}};
            w_fill_nxt    = {CNT_W{1'b0}};
            w_state_nxt   = ST_IDLE;
          end else begin
            w_state_nxt = ST_FLUSH;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_acc     <= {DATA_W{1'b0}};
      r_fill    <= {CNT_W{1'b0}};
      r_bpp     <= 3'd4;
      r_owvalid <= 1'b0;
      r_oword   <= {DATA_W{1'b0}};
      r_obytes  <= {CNT_W{1'b0}};
      r_olast   <= 1'b0;
      r_odrop   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_fill    <= w_fill_nxt;
      r_bpp     <= w_bpp_nxt;
      r_owvalid <= w_owvalid_nxt;
      r_oword   <= w_oword_nxt;
      r_obytes  <= w_obytes_nxt;
      r_olast   <= w_olast_nxt;
      r_odrop   <= w_odrop_nxt;
    end
  end

`ifdef PACKER_STATS_EN
  logic [31:0] r_pix_cnt;
  logic [31:0] r_word_cnt;

  // Per-frame saturating pixel and word-handshake counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pix_cnt  <= 32'd0;
      r_word_cnt <= 32'd0;
    end else if (bus.istart) begin
      r_pix_cnt  <= 32'd0;
      r_word_cnt <= 32'd0;
    end else begin
      if (w_accept && (r_pix_cnt != 32'hFFFF_FFFF)) begin
        r_pix_cnt <= r_pix_cnt + 32'd1;
      end
      if (r_owvalid && bus.oready && (r_word_cnt != 32'hFFFF_FFFF)) begin
        r_word_cnt <= r_word_cnt + 32'd1;
      end
    end
  end

  assign bus.opix_cnt  = r_pix_cnt;
  assign bus.oword_cnt = r_word_cnt;
`else
  assign bus.opix_cnt  = 32'd0;
  assign bus.oword_cnt = 32'd0;
`endif

  assign bus.iready  = w_iready;
  assign bus.owvalid = r_owvalid;
  assign bus.oword   = r_oword;
  assign bus.obytes  = r_obytes;
  assign bus.olast   = r_olast;
  assign bus.odrop   = r_odrop;
endmodule

// File: tb/tb_png_pixel_packer.sv
// Directed self-checking bench for png_pixel_packer; words are collected at the negedge
// whenever owvalid && oready and compared against hand-built byte streams.
module tb_png_pixel_packer;
  localparam int WB = 69;
  localparam int CW = 7;
  localparam int DW = 8 * WB;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] cap_word[$];
  int            cap_bytes[$];
  logic          cap_last[$];

  png_pixel_packer_if #(.WORD_BYTES(WB), .CNT_W(CW)) pif ();
  png_pixel_packer #(.WORD_BYTES(WB), .CNT_W(CW)) dut (.clk(clk), .rstn(rstn), .bus(pif));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && pif.owvalid && pif.oready) begin
      cap_word.push_back(pif.oword);
      cap_bytes.push_back(int'(pif.obytes));
      cap_last.push_back(pif.olast);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_word.delete();
    cap_bytes.delete();
    cap_last.delete();
  endtask

  task automatic start_frame(input logic [2:0] ct);
    pif.istart = 1'b1;
    pif.icolortype = ct;
    step(1);
    pif.istart = 1'b0;
  endtask

  task automatic do_flush();
    pif.iflush = 1'b1;
    step(1);
    pif.iflush = 1'b0;
  endtask

  task automatic drive_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic [7:0] a, input logic flush);
    int n;
    n = 0;
    pif.ivalid = 1'b1;
    pif.ipixelr = r;
    pif.ipixelg = g;
    pif.ipixelb = b;
    pif.ipixela = a;
    @(negedge clk);
    while (!pif.iready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!pif.iready) begin
      checks++;
      errors++;
      $display("FAIL pixel_accept_timeout: iready=%b after %0d cycles, required 1", pif.iready, n);
    end
    pif.iflush = flush;
    step(1);
    pif.ivalid = 1'b0;
    pif.iflush = 1'b0;
  endtask

  task automatic test_reset();
    pif.istart = 1'b0; pif.icolortype = 3'd0; pif.ivalid = 1'b0; pif.iflush = 1'b0;
    pif.ipixelr = 8'd0; pif.ipixelg = 8'd0; pif.ipixelb = 8'd0; pif.ipixela = 8'd0;
    pif.oready = 1'b1;
    rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    step(1);
    checks++; if (pif.iready !== 1'b0) begin errors++; $display("FAIL reset_iready: got %b want 0", pif.iready); end
    checks++; if (pif.owvalid !== 1'b0) begin errors++; $display("FAIL reset_owvalid: got %b want 0", pif.owvalid); end
    checks++; if (pif.oword !== {DW{1'b0}}) begin errors++; $display("FAIL reset_oword: got %h want 0", pif.oword); end
    checks++; if (pif.obytes !== 7'd0) begin errors++; $display("FAIL reset_obytes: got %0d want 0", pif.obytes); end
    checks++; if (pif.olast !== 1'b0 || pif.odrop !== 1'b0) begin errors++; $display("FAIL reset_last_drop: got %b%b want 00", pif.olast, pif.odrop); end
    checks++; if (pif.opix_cnt !== 32'd0 || pif.oword_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", pif.opix_cnt, pif.oword_cnt); end
  endtask

  // RGBA pixels carry bytes 4i..4i+3, so the packed stream is simply 0..91.
  task automatic test_rgba_straddle();
    logic [DW-1:0] exp_w;
    clear_cap();
    pif.oready = 1'b1;
    start_frame(3'd3);
    for (int i = 0; i < 23; i++) drive_pixel(8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 1'b0);
    do_flush();
    step(5);
    checks++; if (cap_word.size() != 2) begin errors++; $display("FAIL rgba_word_count: got %0d want 2", cap_word.size()); end
    if (cap_word.size() == 2) begin
      exp_w = '0;
      for (int k = 0; k < WB; k++) exp_w[8*k +: 8] = 8'(k);
      checks++; if (cap_word[0] !== exp_w) begin errors++; $display("FAIL rgba_word0: got %h want %h", cap_word[0], exp_w); end
      checks++; if (cap_bytes[0] != 69 || cap_last[0] !== 1'b0) begin errors++; $display("FAIL rgba_word0_tag: got %0d/%b want 69/0", cap_bytes[0], cap_last[0]); end
      exp_w = '0;
      for (int k = 0; k < 23; k++) exp_w[8*k +: 8] = 8'(69 + k);
      checks++; if (cap_word[1] !== exp_w) begin errors++; $display("FAIL rgba_word1: got %h want %h", cap_word[1], exp_w); end
      checks++; if (cap_bytes[1] != 23 || cap_last[1] !== 1'b1) begin errors++; $display("FAIL rgba_word1_tag: got %0d/%b want 23/1", cap_bytes[1], cap_last[1]); end
    end
  endtask

  // Final gray pixel arrives with iflush: full word must carry olast one cycle later.
  task automatic test_gray_full_flush();
    logic [DW-1:0] exp_w;
    clear_cap();
    pif.oready = 1'b1;
    start_frame(3'd0);
    for (int i = 0; i < WB; i++) drive_pixel(8'(i), 8'hFF, 8'hEE, 8'hDD, (i == WB - 1));
    exp_w = '0;
    for (int k = 0; k < WB; k++) exp_w[8*k +: 8] = 8'(k);
    checks++; if (pif.owvalid !== 1'b1 || pif.obytes !== 7'd69 || pif.olast !== 1'b1) begin
      errors++; $display("FAIL gray_latency: owvalid/obytes/olast got %b/%0d/%b want 1/69/1", pif.owvalid, pif.obytes, pif.olast); end
    checks++; if (pif.oword !== exp_w) begin errors++; $display("FAIL gray_word: got %h want %h", pif.oword, exp_w); end
    step(2);
    do_flush();
    step(3);
    checks++; if (cap_word.size() != 1) begin errors++; $display("FAIL gray_word_count: got %0d want 1", cap_word.size()); end
    checks++; if (pif.iready !== 1'b0) begin errors++; $display("FAIL gray_idle_iready: got %b want 0", pif.iready); end
  endtask

  // RGB pixel i carries bytes 3i..3i+2; 50 pixels give 150 bytes = 69 + 69 + 12.
  task automatic test_back_to_back_stall();
    logic [DW-1:0] exp_w;
    logic [DW-1:0] exp_w0;
    clear_cap();
    pif.oready = 1'b0;
    start_frame(3'd2);
    for (int i = 0; i < 45; i++) drive_pixel(8'(3*i), 8'(3*i+1), 8'(3*i+2), 8'h00, 1'b0);
    exp_w0 = '0;
    for (int k = 0; k < WB; k++) exp_w0[8*k +: 8] = 8'(k);
    checks++; if (pif.owvalid !== 1'b1 || pif.oword !== exp_w0) begin errors++; $display("FAIL stall_hold_word: owvalid=%b word=%h want 1/%h", pif.owvalid, pif.oword, exp_w0); end
    fork
      drive_pixel(8'd135, 8'd136, 8'd137, 8'h00, 1'b0);
      begin
        repeat (4) @(negedge clk);
        checks++; if (pif.iready !== 1'b0) begin errors++; $display("FAIL stall_iready: got %b want 0", pif.iready); end
        checks++; if (pif.oword !== exp_w0 || pif.obytes !== 7'd69) begin errors++; $display("FAIL stall_stable: got %h/%0d want %h/69", pif.oword, pif.obytes, exp_w0); end
        @(posedge clk);
        #1;
        pif.oready = 1'b1;
      end
    join
    for (int i = 46; i < 50; i++) drive_pixel(8'(3*i), 8'(3*i+1), 8'(3*i+2), 8'h00, (i == 49));
    step(5);
    checks++; if (cap_word.size() != 3) begin errors++; $display("FAIL stall_word_count: got %0d want 3", cap_word.size()); end
    if (cap_word.size() == 3) begin
      for (int w = 0; w < 3; w++) begin
        exp_w = '0;
        for (int k = 0; k < ((w == 2) ? 12 : WB); k++) exp_w[8*k +: 8] = 8'(69*w + k);
        checks++; if (cap_word[w] !== exp_w) begin errors++; $display("FAIL stall_word%0d: got %h want %h", w, cap_word[w], exp_w); end
        checks++; if (cap_bytes[w] != ((w == 2) ? 12 : 69) || cap_last[w] !== (w == 2)) begin
          errors++; $display("FAIL stall_tag%0d: got %0d/%b want %0d/%b", w, cap_bytes[w], cap_last[w], (w == 2) ? 12 : 69, (w == 2)); end
      end
    end
  endtask

  task automatic test_drop();
    logic [DW-1:0] exp_w;
    clear_cap();
    pif.oready = 1'b1;
    start_frame(3'd0);
    for (int i = 0; i < 10; i++) drive_pixel(8'(200 + i), 8'h00, 8'h00, 8'h00, 1'b0);
    start_frame(3'd0);
    checks++; if (pif.odrop !== 1'b1 || pif.owvalid !== 1'b0) begin errors++; $display("FAIL drop_pulse: odrop/owvalid got %b/%b want 1/0", pif.odrop, pif.owvalid); end
    step(1);
    checks++; if (pif.odrop !== 1'b0) begin errors++; $display("FAIL drop_width: got %b want 0", pif.odrop); end
    drive_pixel(8'hAA, 8'h00, 8'h00, 8'h00, 1'b0);
    drive_pixel(8'hBB, 8'h00, 8'h00, 8'h00, 1'b1);
    step(4);
    exp_w = '0;
    exp_w[15:0] = 16'hBBAA;
    checks++; if (cap_word.size() != 1) begin errors++; $display("FAIL drop_word_count: got %0d want 1", cap_word.size()); end
    if (cap_word.size() == 1) begin
      checks++; if (cap_word[0] !== exp_w || cap_bytes[0] != 2 || cap_last[0] !== 1'b1) begin
        errors++; $display("FAIL drop_new_frame: got %h/%0d/%b want %h/2/1", cap_word[0], cap_bytes[0], cap_last[0], exp_w); end
    end
  endtask

  task automatic test_colortypes();
    logic [2:0]    cts    [3] = '{3'd1, 3'd4, 3'd6};
    logic [31:0]   exp_lo [3] = '{32'h0000_4411, 32'h0033_2211, 32'h4433_2211};
    int            exp_n  [3] = '{2, 3, 4};
    logic [DW-1:0] exp_w;
    pif.oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear_cap();
      start_frame(cts[i]);
      drive_pixel(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
      step(4);
      exp_w = '0;
      exp_w[31:0] = exp_lo[i];
      checks++; if (cap_word.size() != 1) begin errors++; $display("FAIL ct%0d_count: got %0d want 1", cts[i], cap_word.size()); end
      if (cap_word.size() == 1) begin
        checks++; if (cap_word[0] !== exp_w || cap_bytes[0] != exp_n[i]) begin
          errors++; $display("FAIL ct%0d_word: got %h/%0d want %h/%0d", cts[i], cap_word[0], cap_bytes[0], exp_w, exp_n[i]); end
      end
    end
  endtask

  task automatic test_async_reset();
    clear_cap();
    pif.oready = 1'b0;
    start_frame(3'd3);
    drive_pixel(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    step(1);
    checks++; if (pif.owvalid !== 1'b1 || pif.obytes !== 7'd4) begin errors++; $display("FAIL areset_pre: owvalid/obytes got %b/%0d want 1/4", pif.owvalid, pif.obytes); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (pif.owvalid !== 1'b0 || pif.oword !== {DW{1'b0}}) begin errors++; $display("FAIL areset_out: owvalid/oword got %b/%h want 0/0", pif.owvalid, pif.oword); end
    checks++; if (pif.obytes !== 7'd0 || pif.olast !== 1'b0 || pif.iready !== 1'b0) begin
      errors++; $display("FAIL areset_misc: obytes/olast/iready got %0d/%b/%b want 0/0/0", pif.obytes, pif.olast, pif.iready); end
    step(2);
    rstn = 1'b1;
    pif.oready = 1'b1;
    step(4);
    checks++; if (cap_word.size() != 0) begin errors++; $display("FAIL areset_no_word: got %0d words want 0", cap_word.size()); end
  endtask

  // 46 RGBA pixels = 184 bytes = 69 + 69 + 46.
  task automatic test_stats();
    int exp_pix;
    int exp_words;
`ifdef PACKER_STATS_EN
    exp_pix = 46;
    exp_words = 3;
`else
    exp_pix = 0;
    exp_words = 0;
`endif
    clear_cap();
    pif.oready = 1'b1;
    start_frame(3'd3);
    for (int i = 0; i < 46; i++) drive_pixel(8'(i), 8'(i), 8'(i), 8'(i), 1'b0);
    do_flush();
    step(5);
    checks++; if (cap_word.size() != 3) begin errors++; $display("FAIL stats_word_count: got %0d want 3", cap_word.size()); end
    if (cap_word.size() == 3) begin
      checks++; if (cap_bytes[0] != 69 || cap_bytes[1] != 69 || cap_bytes[2] != 46 || cap_last[2] !== 1'b1) begin
        errors++; $display("FAIL stats_sizes: got %0d/%0d/%0d last %b want 69/69/46 last 1", cap_bytes[0], cap_bytes[1], cap_bytes[2], cap_last[2]); end
    end
    checks++; if (pif.opix_cnt !== 32'(exp_pix)) begin errors++; $display("FAIL stats_pix: got %0d want %0d", pif.opix_cnt, exp_pix); end
    checks++; if (pif.oword_cnt !== 32'(exp_words)) begin errors++; $display("FAIL stats_words: got %0d want %0d", pif.oword_cnt, exp_words); end
    start_frame(3'd3);
    checks++; if (pif.opix_cnt !== 32'd0 || pif.oword_cnt !== 32'd0) begin errors++; $display("FAIL stats_clear: got %0d/%0d want 0/0", pif.opix_cnt, pif.oword_cnt); end
    do_flush();
    step(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rgba_straddle();
    test_gray_full_flush();
    test_back_to_back_stall();
    test_drop();
    test_colortypes();
    test_async_reset();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
